rgmii_tx_encoder: RTL

RGMII_TX_ENCODER -- requirements
Module: rgmii_tx_encoder

---
 rtl/rgmii_pkg.sv | 6 +
 rtl/mii_nibble_timer.sv | 38 +++
 rtl/rgmii_tx_encoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and defaults for the RGMII transmit encoder.
package rgmii_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW_NIB = 2'd1, HIGH_NIB = 2'd2} nib_state_e;
  typedef enum logic {GMII = 1'b0, MII = 1'b1} mode_e;
  localparam int unsigned MII_DIV_DEFAULT = 5;
endpackage

// File: rtl/mii_nibble_timer.sv
// Free-running nibble period counter for MII mode; also produces the forwarded clock level.
module mii_nibble_timer #(
  parameter int unsigned DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic wrap,
  output logic txc_level
);
  localparam logic [7:0] LAST = 8'(DIV - 1);
  localparam logic [7:0] HALF = 8'((DIV + 1) / 2);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // next count: run 0..DIV-1 while enabled, park at zero otherwise
  always_comb begin
    cnt_d = 8'd0;
    if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap      = enable && (cnt_q == LAST);
  assign txc_level = (cnt_q < HALF);
endmodule

// File: rtl/rgmii_tx_encoder.sv
// RGMII transmit encoder: byte-per-cycle GMII or nibble-serialised MII onto DDR output halves.
module rgmii_tx_encoder
  import rgmii_pkg::*;
#(
  parameter int unsigned MII_DIV = MII_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mii_select,
  input  logic [7:0] rgmii_mac_tx_data,
  input  logic       rgmii_mac_tx_dv,
  input  logic       rgmii_mac_tx_er,
  output logic       rgmii_mac_tx_rdy,
  output logic [3:0] txd_rise,
  output logic [3:0] txd_fall,
  output logic       tx_ctl_rise,
  output logic       tx_ctl_fall,
  output logic       txc_rise,
  output logic       txc_fall
);
  mode_e      mode_q, mode_d;
  nib_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       lat_dv_q, lat_dv_d;
  logic       lat_er_q, lat_er_d;
  logic       seen_dv_q, seen_dv_d;
  logic       run_q;
  logic [3:0] txd_rise_q, txd_rise_d;
  logic [3:0] txd_fall_q, txd_fall_d;
  logic       ctl_rise_q, ctl_rise_d;
  logic       ctl_fall_q, ctl_fall_d;
  logic       rdy_s;
  logic       wrap_s;
  logic       txc_level_s;
  logic       idle_s;

  mii_nibble_timer #(.DIV(MII_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (mode_q == MII),
    .wrap      (wrap_s),
    .txc_level (txc_level_s)
  );

  // ready strobe; run_q keeps it low until the first edge after reset
  always_comb begin
    rdy_s = 1'b0;
    if (!run_q) begin
      rdy_s = 1'b0;
    end else if (mode_q == GMII) begin
      rdy_s = 1'b1;
    end else begin
      rdy_s = wrap_s && ((state_q == IDLE) || (state_q == HIGH_NIB));
    end
  end

  // frame sequencing, mode selection and next output values
  always_comb begin
    mode_d     = mode_q;
    state_d    = state_q;
    byte_d     = byte_q;
    lat_dv_d   = lat_dv_q;
    lat_er_d   = lat_er_q;
    seen_dv_d  = seen_dv_q;
    txd_rise_d = 4'd0;
    txd_fall_d = 4'd0;
    ctl_rise_d = 1'b0;
    ctl_fall_d = 1'b0;

    if (rdy_s) begin
      seen_dv_d = rgmii_mac_tx_dv;
    end else begin
      seen_dv_d = seen_dv_q;
    end

    // a frame starting in this very cycle pins the mode it started in
    idle_s = (state_q == IDLE) && !seen_dv_q;
    if (idle_s && !(rdy_s && rgmii_mac_tx_dv)) begin
      mode_d = mode_e'(mii_select);
    end else begin
      mode_d = mode_q;
    end

    case (state_q)
      IDLE: begin
        if ((mode_q == MII) && rdy_s && rgmii_mac_tx_dv) begin
          state_d  = LOW_NIB;
          byte_d   = rgmii_mac_tx_data;
          lat_dv_d = rgmii_mac_tx_dv;
          lat_er_d = rgmii_mac_tx_er;
        end else begin
          state_d = IDLE;
        end
      end
      LOW_NIB: begin
        if (wrap_s) begin
          state_d = HIGH_NIB;
        end else begin
          state_d = LOW_NIB;
        end
      end
      HIGH_NIB: begin
        if (rdy_s && rgmii_mac_tx_dv) begin
          state_d  = LOW_NIB;
          byte_d   = rgmii_mac_tx_data;
          lat_dv_d = rgmii_mac_tx_dv;
          lat_er_d = rgmii_mac_tx_er;
        end else if (rdy_s) begin
          state_d = IDLE;
        end else begin
          state_d = HIGH_NIB;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((mode_q == GMII) && rdy_s) begin
      txd_rise_d = rgmii_mac_tx_data[3:0];
      txd_fall_d = rgmii_mac_tx_data[7:4];
      ctl_rise_d = rgmii_mac_tx_dv;
      ctl_fall_d = rgmii_mac_tx_dv ^ rgmii_mac_tx_er;
    end else if (mode_q == MII) begin
      case (state_d)
        LOW_NIB: begin
          txd_rise_d = byte_d[3:0];
          txd_fall_d = byte_d[3:0];
          ctl_rise_d = lat_dv_d;
          ctl_fall_d = lat_dv_d ^ lat_er_d;
        end
        HIGH_NIB: begin
          txd_rise_d = byte_d[7:4];
          txd_fall_d = byte_d[7:4];
          ctl_rise_d = lat_dv_d;
          ctl_fall_d = lat_dv_d ^ lat_er_d;
        end
        default: begin
          txd_rise_d = 4'd0;
          txd_fall_d = 4'd0;
          ctl_rise_d = 1'b0;
          ctl_fall_d = 1'b0;
        end
      endcase
    end else begin
      txd_rise_d = 4'd0;
      txd_fall_d = 4'd0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= GMII;
      state_q    <= IDLE;
      byte_q     <= 8'd0;
      lat_dv_q   <= 1'b0;
      lat_er_q   <= 1'b0;
      seen_dv_q  <= 1'b0;
      run_q      <= 1'b0;
      txd_rise_q <= 4'd0;
      txd_fall_q <= 4'd0;
      ctl_rise_q <= 1'b0;
      ctl_fall_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      lat_dv_q   <= lat_dv_d;
      lat_er_q   <= lat_er_d;
      seen_dv_q  <= seen_dv_d;
      run_q      <= 1'b1;
      txd_rise_q <= txd_rise_d;
      txd_fall_q <= txd_fall_d;
      ctl_rise_q <= ctl_rise_d;
      ctl_fall_q <= ctl_fall_d;
    end
  end

  assign rgmii_mac_tx_rdy = rdy_s;
  assign txd_rise         = txd_rise_q;
  assign txd_fall         = txd_fall_q;
  assign tx_ctl_rise      = ctl_rise_q;
  assign tx_ctl_fall      = ctl_fall_q;
  // GMII forwards a constant 1/0 pattern (a full clk period); reset leaves the mode at GMII
  assign txc_rise         = (mode_q == MII) ? txc_level_s : 1'b1;
  assign txc_fall         = (mode_q == MII) ? txc_level_s : 1'b0;
endmodule
